// File: rtl/demux_serial_router.sv
// Serial feeder for the 1-to-4 demux: buffers one {dest, payload} frame and shifts it out MSB-first on i with s held.
// Optional build macro DEMUX_SERIAL_ROUTER_PARITY_EN appends an even-parity bit after the payload.
module demux_serial_router #(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              i,
    output logic [1:0]        s,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a frame transfers at a rising edge where in_valid && in_ready;
    // in_ready is !buf_full_q, so it never depends combinationally on in_valid.

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = 4;

    // IDLE is encoded as zero so dbg_state_o == 0 means idle.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
`else
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
`endif
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic             GAP_EN   = (GAP_CYC > 0);

    logic [1:0]        state_q,    state_d;
    logic              buf_full_q, buf_full_d;
    logic [1:0]        buf_dest_q, buf_dest_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic              i_q,        i_d;
    logic [1:0]        s_q,        s_d;
    logic              done_q,     done_d;
`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
    logic              par_q,      par_d;
`endif

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_dest_d = buf_dest_q;
        buf_data_d = buf_data_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        i_d        = i_q;
        s_d        = s_q;
        done_d     = 1'b0;
`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
        par_d      = par_q;
`endif

        if (in_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_dest_d = in_dest;
            buf_data_d = in_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    // The MSB goes straight onto i so the first bit appears in the first SHIFT cycle.
                    i_d        = buf_data_q[DATA_W-1];
                    shift_d    = buf_data_q << 1;
                    s_d        = buf_dest_q;
                    cnt_d      = CNT_LOAD;
                    buf_full_d = 1'b0;
`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
                    par_d      = ^buf_data_q;
`endif
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    i_d    = 1'b0;
                    done_d = 1'b1;
                    if (GAP_EN) begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    shift_d = shift_q << 1;
`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
                    i_d     = (cnt_q == CNT_W'(1)) ? par_q : shift_q[DATA_W-1];
`else
                    i_d     = shift_q[DATA_W-1];
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                i_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            buf_full_q <= 1'b0;
            buf_dest_q <= 2'b00;
            buf_data_q <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            i_q        <= 1'b0;
            s_q        <= 2'b00;
            done_q     <= 1'b0;
`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_dest_q <= buf_dest_d;
            buf_data_q <= buf_data_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            i_q        <= i_d;
            s_q        <= s_d;
            done_q     <= done_d;
`ifdef DEMUX_SERIAL_ROUTER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign in_ready    = !buf_full_q;
    assign i           = i_q;
    assign s           = s_q;
    assign busy        = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign frame_done  = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/demux_serial_router.md
Name: demux_serial_router

Overview:
- Upstream feeder for the 1-to-4 structural demultiplexer.
- Accepts parallel frames of {destination, payload} over a valid/ready handshake and buffers one pending frame.
- Serialises the payload MSB-first onto the demux data input `i`, holding the demux select `s` at the frame's destination for the whole frame.
- Inserts a programmable idle gap between frames so each demux output sees clean, separated bursts.

Parameters:
- DATA_W, 8: payload width in bits; legal range 2..32.
- GAP_CYC, 1: idle cycles (`i`=0) between the end of one frame and the start of the next; legal range 0..15.

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: upstream frame valid.
- in_ready, output, 1: block can accept a frame this cycle.
- in_dest, input, 2: destination channel 0..3; becomes `s`.
- in_data, input, DATA_W: payload.
- i, output, 1: serial data to demux input `i`.
- s, output, 2: select to demux input `s`.
- busy, output, 1: high while state is SHIFT or GAP.
- frame_done, output, 1: one-cycle pulse after the last bit of a frame.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; i=0; s=2'b00; busy=0; frame_done=0.
  - Pending buffer empty, so in_ready=1 immediately.
  - Shift register and counters cleared.
- Reset mid-frame aborts the frame with no frame_done; the pending frame is discarded.
- Pending buffer (1 entry):
  - in_ready = !buf_full (registered state, no combinational path from in_valid).
  - Transfer occurs at an edge where in_valid && in_ready; in_dest and in_data are captured and buf_full is set.
  - in_data and in_dest are ignored when no transfer occurs.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE, buf_full=1: at the next edge, load shifter with buffered data, set s<=buffered dest, clear buf_full, load bit counter with DATA_W-1, go to SHIFT.
  - IDLE, buf_full=0: remain in IDLE.
  - SHIFT: i = shifter MSB, registered (changes only at edges). Shift left each edge and decrement the counter. When the counter is 0 at an edge, leave SHIFT: go to GAP if GAP_CYC>0, else IDLE.
  - GAP: i=0 for exactly GAP_CYC cycles, then IDLE.
  - frame_done pulses high for the single cycle immediately after the last SHIFT cycle.
- Output rules:
  - s holds the last destination outside SHIFT; it never changes during SHIFT.
  - i=0 in IDLE and GAP.
- Latency: transfer at edge T0 → SHIFT entered at T1 → bit MSB on i during cycle T1..T2.
  - Frame occupies DATA_W cycles, or DATA_W+1 with PARITY_EN.
- Simultaneous events:
  - A new transfer is accepted during SHIFT/GAP (buffer refills while shifting).
  - A transfer at the same edge that IDLE loads from the buffer is impossible, because in_ready=0 while buf_full.
  - After a load clears the buffer, in_ready rises the next cycle.
- Back-to-back throughput: one frame per DATA_W+GAP_CYC+1 cycles; the +1 is the IDLE load cycle.
- No wrap-around hazard: the counter width is $clog2(DATA_W+1) and it is reloaded per frame.

Optional Feature:
- Macro: DEMUX_SERIAL_ROUTER_PARITY_EN.
- When defined: one extra SHIFT cycle follows the payload carrying even parity (XOR of all payload bits) on i. frame_done pulses after the parity bit.
- When undefined: no parity bit; frame length is exactly DATA_W; no parity logic synthesised.

Test Plan:
- Reset then idle: assert rst mid-cycle with no clock edge → i=0, s=0, busy=0, in_ready=1 immediately; release, hold in_valid=0 for 10 cycles → outputs unchanged.
- Single frame: dest=2'b10, data=8'hA5, GAP_CYC=1 → s=2 from T1; i=1,0,1,0,0,1,0,1 over 8 cycles; frame_done pulse in cycle 9; busy high cycles 1..9; demux d2 mirrors i, d0/d1/d3 stay 0.
- Back-to-back: frames (3,8'hFF) then (0,8'h01) held valid continuously → second accepted during first SHIFT; in_ready low until first load; second frame starts exactly DATA_W+GAP_CYC+1 cycles after first; s switches 3→0 only at the load edge.
- Backpressure: in_valid held with buffer full → in_ready=0, in_data changes ignored; buffered value shifted out unchanged.
- Reset mid-frame: rst asserted at bit 4 of (1,8'hC3) → i=0, s=0 asynchronously; no frame_done; the pending frame is lost; normal operation resumes after release.
- PARITY_EN defined: (1,8'h07) → 9 SHIFT cycles, 9th bit=1; frame_done one cycle later. With 8'h03 → parity bit 0.
